// File: rtl/washing_machine_pkg.sv
// Shared types and default constants for the washing machine controller and plant.
// No logic: fault codes, default plant parameters and the controller state encoding.
package washing_machine_pkg;

   typedef enum logic [2:0] {
      FLT_NONE     = 3'd0,
      FLT_UNLOCKED = 3'd1,
      FLT_MULTI    = 3'd2,
      FLT_DRY_HEAT = 3'd3
   } fault_code_t;

   localparam int WM_TICK_DIV   = 50000;
   localparam int WM_LEVEL_FULL = 200;
   localparam int WM_TEMP_AMB   = 20;
   localparam int WM_TEMP_HOT   = 60;
   localparam int WM_TEMP_MAX   = 95;
   localparam int WM_WASH_TICKS = 1000;
   localparam int WM_SPIN_TICKS = 500;

   typedef enum logic [2:0] {
      WM_IDLE,
      WM_LOCK,
      WM_FILL,
      WM_HEAT,
      WM_WASH,
      WM_DRAIN,
      WM_SPIN,
      WM_DONE
   } wm_state_t;

endpackage

// File: rtl/wm_tick_gen.sv
// Model tick prescaler: tick is high for one cycle every TICK_DIV cycles.
// Latency: first tick TICK_DIV cycles after reset release; no backpressure.
module wm_tick_gen
   import washing_machine_pkg::*;
#(
   parameter int TICK_DIV = WM_TICK_DIV
) (
   input  logic clk50m,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(TICK_DIV - 1));
   assign tick   = w_last;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/washing_machine_plant.sv
// Washing machine plant model: actuators in, sensors out; state advances on the model tick.
// Sensors are combinational on registered state; optional fault checker under WM_PLANT_FAULT_EN.
module washing_machine_plant
   import washing_machine_pkg::*;
#(
   parameter int TICK_DIV   = WM_TICK_DIV,
   parameter int LEVEL_FULL = WM_LEVEL_FULL,
   parameter int TEMP_AMB   = WM_TEMP_AMB,
   parameter int TEMP_HOT   = WM_TEMP_HOT,
   parameter int TEMP_MAX   = WM_TEMP_MAX,
   parameter int WASH_TICKS = WM_WASH_TICKS,
   parameter int SPIN_TICKS = WM_SPIN_TICKS
) (
   input  logic       clk50m,
   input  logic       rst_n,
   input  logic       door_lock,
   input  logic       valve,
   input  logic       heater,
   input  logic       motor_wash,
   input  logic       motor_spin,
   input  logic       pump,
   output logic       full,
   output logic       hot,
   output logic       clean,
   output logic       dry,
   output logic [7:0] level,
   output logic [6:0] temp,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [7:0]  LV_FULL  = 8'(LEVEL_FULL);
   localparam logic [6:0]  TP_AMB   = 7'(TEMP_AMB);
   localparam logic [6:0]  TP_HOT   = 7'(TEMP_HOT);
   localparam logic [6:0]  TP_MAX   = 7'(TEMP_MAX);
   localparam logic [15:0] WASH_MAX = 16'(WASH_TICKS);
   localparam logic [15:0] SPIN_MAX = 16'(SPIN_TICKS);

   logic        w_tick;
   logic [7:0]  r_level;
   logic [6:0]  r_temp;
   logic [1:0]  r_cool;
   logic [15:0] r_wash;
   logic [15:0] r_spin;
   logic        r_lock_d;
   logic        w_fill;
   logic        w_drain;
   logic        w_heat;
   logic        w_new_load;

   wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk50m (clk50m),
      .rst_n  (rst_n),
      .tick   (w_tick)
   );

   assign w_fill     = valve & ~pump;
   assign w_drain    = pump & ~valve;
   assign w_heat     = heater & (r_level != 8'd0);
   assign w_new_load = r_lock_d & ~door_lock;

   // A heater on an empty drum freezes temperature, including any cooldown.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 8'd0;
         r_temp  <= TP_AMB;
         r_cool  <= 2'd0;
      end else if (w_tick) begin
         if (w_fill && (r_level < LV_FULL)) begin
            r_level <= r_level + 8'd1;
         end else if (w_drain && (r_level != 8'd0)) begin
            r_level <= r_level - 8'd1;
         end
         if (w_heat) begin
            r_cool <= 2'd0;
            if (r_temp < TP_MAX) begin
               r_temp <= r_temp + 7'd1;
            end
         end else if (!heater && (r_temp > TP_AMB)) begin
            r_cool <= r_cool + 2'd1;
            if (r_cool == 2'd3) begin
               r_temp <= r_temp - 7'd1;
            end
         end
      end
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_lock_d <= 1'b0;
         r_wash   <= 16'd0;
         r_spin   <= 16'd0;
      end else begin
         r_lock_d <= door_lock;
         if (w_new_load) begin
            r_wash <= 16'd0;
            r_spin <= 16'd0;
         end else if (w_tick) begin
            if (motor_wash && full && hot && (r_wash < WASH_MAX)) begin
               r_wash <= r_wash + 16'd1;
            end
            if (motor_spin && (r_spin < SPIN_MAX)) begin
               r_spin <= r_spin + 16'd1;
            end
         end
      end
   end

   assign level = r_level;
   assign temp  = r_temp;
   assign full  = (r_level >= LV_FULL);
   assign hot   = (r_temp >= TP_HOT);
   assign clean = (r_wash >= WASH_MAX);
   assign dry   = (r_spin >= SPIN_MAX);

`ifdef WM_PLANT_FAULT_EN
   fault_code_t w_cause;
   fault_code_t r_fault_code;
   logic        r_fault;
   logic [2:0]  w_n_act;

   assign w_n_act = 3'(valve) + 3'(heater) + 3'(motor_wash) + 3'(motor_spin) + 3'(pump);

   always_comb begin
      w_cause = FLT_NONE;
      if (!door_lock && (w_n_act != 3'd0)) begin
         w_cause = FLT_UNLOCKED;
      end else if (w_n_act >= 3'd2) begin
         w_cause = FLT_MULTI;
      end else if (heater && (r_level == 8'd0)) begin
         w_cause = FLT_DRY_HEAT;
      end
   end

   // Only the first cause is kept; the flag is sticky until reset.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         r_fault      <= 1'b0;
         r_fault_code <= FLT_NONE;
      end else if (!r_fault && (w_cause != FLT_NONE)) begin
         r_fault      <= 1'b1;
         r_fault_code <= w_cause;
      end
   end

   assign fault      = r_fault;
   assign fault_code = r_fault_code;
`else
   assign fault      = 1'b0;
   assign fault_code = 3'd0;
`endif

endmodule

// File: tb/tb_washing_machine_plant.sv
// Directed bench for washing_machine_plant with small model constants.
// Fault expectations follow whether WM_PLANT_FAULT_EN is defined for the build.
module tb_washing_machine_plant;

`ifdef WM_PLANT_FAULT_EN
   localparam int FEN = 1;
`else
   localparam int FEN = 0;
`endif

   logic       clk50m = 1'b0;
   logic       rst_n;
   logic       door_lock, valve, heater, motor_wash, motor_spin, pump;
   logic       full, hot, clean, dry, fault;
   logic [7:0] level;
   logic [6:0] temp;
   logic [2:0] fault_code;

   int passed = 0;
   int total  = 0;

   always #5 clk50m = ~clk50m;

   washing_machine_plant #(
      .TICK_DIV   (4),
      .LEVEL_FULL (10),
      .TEMP_AMB   (20),
      .TEMP_HOT   (25),
      .TEMP_MAX   (95),
      .WASH_TICKS (3),
      .SPIN_TICKS (2)
   ) dut (
      .clk50m     (clk50m),
      .rst_n      (rst_n),
      .door_lock  (door_lock),
      .valve      (valve),
      .heater     (heater),
      .motor_wash (motor_wash),
      .motor_spin (motor_spin),
      .pump       (pump),
      .full       (full),
      .hot        (hot),
      .clean      (clean),
      .dry        (dry),
      .level      (level),
      .temp       (temp),
      .fault      (fault),
      .fault_code (fault_code)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk50m);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_level"}, int'(level), 0);
      check({tag, "_temp"},  int'(temp), 20);
      check({tag, "_full"},  int'(full), 0);
      check({tag, "_hot"},   int'(hot), 0);
      check({tag, "_clean"}, int'(clean), 0);
      check({tag, "_dry"},   int'(dry), 0);
      check({tag, "_fault"}, int'(fault), 0);
      check({tag, "_code"},  int'(fault_code), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      door_lock = 0; valve = 0; heater = 0; motor_wash = 0; motor_spin = 0; pump = 0;
      step(3);
      check_reset_outputs("rst");

      // Fill
      rst_n = 1'b1; door_lock = 1; valve = 1;
      step(12); check("fill_lvl3", int'(level), 3);
      step(24); check("fill_lvl9", int'(level), 9);
                check("fill_notfull", int'(full), 0);
      step(4);  check("fill_lvl10", int'(level), 10);
                check("fill_full", int'(full), 1);
      step(8);  check("fill_sat", int'(level), 10);

      // Heat
      valve = 0; heater = 1;
      step(16); check("heat_t24", int'(temp), 24);
                check("heat_nothot", int'(hot), 0);
      step(4);  check("heat_t25", int'(temp), 25);
                check("heat_hot", int'(hot), 1);

      // Wash while cooling
      heater = 0; motor_wash = 1;
      step(12); check("wash_clean", int'(clean), 1);
                check("cool_t25_hold", int'(temp), 25);

      // Spin
      motor_wash = 0; motor_spin = 1;
      step(4);  check("cool_t24", int'(temp), 24);
                check("spin_notdry", int'(dry), 0);
      step(4);  check("spin_dry", int'(dry), 1);
                check("spin_clean_hold", int'(clean), 1);

      // New load
      door_lock = 0; motor_spin = 0;
      step(1);  check("newload_clean", int'(clean), 0);
                check("newload_dry", int'(dry), 0);
                check("newload_level", int'(level), 10);

      // Drain
      door_lock = 1; pump = 1;
      step(3);  check("drain_lvl9", int'(level), 9);
                check("drain_notfull", int'(full), 0);
      step(36); check("drain_lvl0", int'(level), 0);
      step(8);  check("drain_sat", int'(level), 0);

      // Fault: actuator while unlocked, then a later fault is ignored
      pump = 0; door_lock = 0; valve = 1;
      step(1);  check("flt_unlock", int'(fault), FEN);
                check("flt_unlock_code", int'(fault_code), FEN * 1);
      door_lock = 1; heater = 1;
      step(1);  check("flt_second_code", int'(fault_code), FEN * 1);
      valve = 0; heater = 0; rst_n = 1'b0;
      #1;       check("flt_rst_fault", int'(fault), 0);
      @(posedge clk50m); #1; rst_n = 1'b1;

      // Fault: multiple actuators
      door_lock = 1; valve = 1; heater = 1;
      step(1);  check("flt_multi", int'(fault), FEN);
                check("flt_multi_code", int'(fault_code), FEN * 2);
      valve = 0; heater = 0; rst_n = 1'b0;
      #1;
      @(posedge clk50m); #1; rst_n = 1'b1;

      // Fault: heater on empty drum
      door_lock = 1; heater = 1;
      step(1);  check("flt_dry", int'(fault), FEN);
                check("flt_dry_code", int'(fault_code), FEN * 3);
      step(8);  check("flt_dry_temp", int'(temp), 20);

      // Reset mid-fill with fault held
      heater = 0; valve = 1;
      step(19); check("mid_lvl5", int'(level), 5);
                check("mid_fault", int'(fault), FEN);
                check("mid_code", int'(fault_code), FEN * 3);
      rst_n = 1'b0;
      #1;       check_reset_outputs("midrst");
      @(posedge clk50m); #1; rst_n = 1'b1;
      step(3);  check("post_rst_notick", int'(level), 0);
      step(1);  check("post_rst_tick", int'(level), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
